// File: rtl/four_bit_seq_divider_if.sv
// four_bit_seq_divider_if
//   Interface bundle for the sequential restoring divider. It groups the
//   start/busy/done handshake, the operand inputs and the registered results.
//   The clock and reset are not part of the bundle and stay plain ports.
//
//   Signals
//     start        request, seen by the divider only in IDLE or DONE
//     Dividend     unsigned dividend, captured on an accepted start
//     Divisor      unsigned divisor, captured on an accepted start
//     Quotient     registered quotient
//     Remainder    registered remainder
//     busy         high while the divider is iterating
//     done         one-cycle pulse that marks a valid result
//     div_by_zero  result came from a zero divisor; held until the next start
//
//   Modports
//     master  requester side: drives start and the operands
//     slave   divider side: drives the results and status
interface four_bit_seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, Dividend, Divisor,
        input  Quotient, Remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, Dividend, Divisor,
        output Quotient, Remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/four_bit_seq_divider.sv
// four_bit_seq_divider
//   Unsigned restoring divider that produces one quotient bit per clock. A
//   zero divisor is caught when start is accepted, and the block goes
//   straight to DONE without iterating.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    four_bit_seq_divider_if.slave (start/operands in, results out)
//
//   Timing (WIDTH = 4)
//     A start is accepted on edge 0. The divider iterates on edges 1..WIDTH
//     with busy high, and done is high for the cycle after edge WIDTH. A start
//     seen in DONE is accepted at once, so divides can run back to back.
module four_bit_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    four_bit_seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] d;        // captured divisor
    logic [WIDTH-1:0] q;        // working quotient; shifts the dividend out at the top
    logic [WIDTH-1:0] r;        // partial remainder
    logic [CW-1:0]    cnt;      // iterations completed

    // One restoring step on {r,q}.
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
        trial = {1'b0, r_sh} - {1'b0, d};
        r_nxt = r_sh;
        q_nxt = {q[WIDTH-2:0], 1'b0};
        // A clear borrow bit means the divisor fit: keep the difference and
        // shift in a 1. Otherwise keep the shifted remainder, which is the
        // restore step.
        if (!trial[WIDTH]) begin
            r_nxt = trial[WIDTH-1:0];
            q_nxt = {q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            d               <= '0;
            q               <= '0;
            r               <= '0;
            cnt             <= '0;
            bus.Quotient    <= '0;
            bus.Remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                    if (bus.start) begin
                        if (bus.Divisor == '0) begin
                            // Report the result right away. busy stays low.
                            bus.Quotient    <= '1;
                            bus.Remainder   <= bus.Dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            d               <= bus.Divisor;
                            q               <= bus.Dividend;
                            r               <= '0;
                            cnt             <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    // start and the operand inputs are ignored while iterating.
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.Quotient  <= q_nxt;
                        bus.Remainder <= r_nxt;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_four_bit_seq_divider.sv
// tb_four_bit_seq_divider
//   Self-checking bench for four_bit_seq_divider. Inputs are driven on the
//   falling edge and outputs are sampled on the falling edge. The expected
//   results come from plain integer division (/ and %). The expected timing
//   comes from the documented edge counts.
module tb_four_bit_seq_divider;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    four_bit_seq_divider_if #(.WIDTH(WIDTH)) bus ();

    four_bit_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned division, with the zero-divisor rule.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 15 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Run one divide. If noise is set, start is pulsed with other operands
    // during RUN and the operand inputs keep changing. Neither may affect
    // the result.
    task automatic do_div(input int a, input int b, input bit noise);
        int  k;
        int  nbusy;
        int  pq;
        int  pr;
        bit  moved;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.Dividend = a[3:0];
        bus.Divisor  = b[3:0];
        @(negedge clk);             // edge 0 has sampled start
        bus.start = 1'b0;
        k     = 0;
        nbusy = 0;
        moved = 0;
        pq    = int'(bus.Quotient);
        pr    = int'(bus.Remainder);
        while (!bus.done && k < 20) begin
            if (bus.busy) nbusy++;
            if (b != 0 && (int'(bus.Quotient) != pq || int'(bus.Remainder) != pr)) moved = 1;
            if (noise) begin
                bus.start    = (k == 1);
                bus.Dividend = (k == 1) ? 4'd8 : 4'($urandom_range(0, 15));
                bus.Divisor  = (k == 1) ? 4'd2 : 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk("done_latency", k, (b == 0) ? 0 : WIDTH);
        chk("busy_cycles", nbusy, (b == 0) ? 0 : WIDTH);
        chk("hold_during_run", int'(moved), 0);
        chk("quotient", int'(bus.Quotient), ref_q(a, b));
        chk("remainder", int'(bus.Remainder), ref_r(a, b));
        chk("div_by_zero", int'(bus.div_by_zero), int'(b == 0));
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("result_held", int'(bus.Quotient), ref_q(a, b));
    endtask

    int  t_first;
    int  cyc;
    int  nd;

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", int'(bus.Quotient), 0);
        chk("rst_remainder", int'(bus.Remainder), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_dbz", int'(bus.div_by_zero), 0);
        rst_n = 1'b1;

        // Directed cases
        do_div(13, 4, 0);
        do_div(15, 1, 0);
        do_div(3, 7, 0);
        do_div(5, 0, 0);
        do_div(9, 3, 0);
        do_div(13, 4, 1);           // start and operand changes during RUN

        // Back-to-back: start held high, second operands shown in DONE.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.Dividend = 4'd14;
        bus.Divisor  = 4'd3;
        cyc = 0;
        nd  = 0;
        t_first = -1;
        while (nd < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                nd++;
                if (nd == 1) begin
                    t_first = cyc;
                    chk("b2b_q1", int'(bus.Quotient), ref_q(14, 3));
                    chk("b2b_r1", int'(bus.Remainder), ref_r(14, 3));
                    bus.Dividend = 4'd7;
                    bus.Divisor  = 4'd7;
                end else begin
                    chk("b2b_gap", cyc - t_first, WIDTH + 1);
                    chk("b2b_q2", int'(bus.Quotient), ref_q(7, 7));
                    chk("b2b_r2", int'(bus.Remainder), ref_r(7, 7));
                end
            end else if (nd == 1 && cyc == t_first + 1) begin
                chk("b2b_busy_next", int'(bus.busy), 1);
            end
        end
        chk("b2b_done_count", nd, 2);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a run
        bus.start    = 1'b1;
        bus.Dividend = 4'd15;
        bus.Divisor  = 4'd2;
        @(posedge clk);             // edge 0
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);  // edges 1, 2
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_quotient", int'(bus.Quotient), 0);
        chk("mid_rst_remainder", int'(bus.Remainder), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_dbz", int'(bus.div_by_zero), 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("mid_rst_no_done", nd, 0);
        do_div(10, 3, 0);

        // Random operands, zero divisors included
        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            do_div(a, b, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/four_bit_seq_divider.md
# four_bit_seq_divider

Sequential restoring divider for unsigned 4-bit operands. It produces a quotient and remainder by repeated trial subtraction, one quotient bit per clock, behind a start/busy/done handshake. It sits beside the combinational add/subtract datapath as its inverse arithmetic unit: where that path accumulates, this block peels off the divisor one shifted subtraction at a time. Divide-by-zero is detected and flagged rather than iterated.

## Interface
- WIDTH, 4, operand/result width in bits; iteration count equals WIDTH
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising clk edge only in IDLE or DONE
- Dividend  input  WIDTH  unsigned dividend, captured on accepted start
- Divisor  input  WIDTH  unsigned divisor, captured on accepted start
- Quotient  output  WIDTH  result quotient, registered
- Remainder  output  WIDTH  result remainder, registered
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse marking result valid
- div_by_zero  output  1  set with done when captured Divisor == 0; held until next accepted start

## Operation
- Reset values: Quotient = 0, Remainder = 0, busy = 0, done = 0, div_by_zero = 0; state = IDLE; iteration counter = 0.
- States are IDLE, RUN and DONE.
- **IDLE**, start = 1, Divisor != 0:
  - Latch the divisor into register D.
  - Load working quotient Q = Dividend and partial remainder R = 0.
  - Clear counter and div_by_zero; go to RUN.
- **IDLE**, start = 1, Divisor == 0:
  - Quotient = all ones, Remainder = Dividend, div_by_zero = 1.
  - Go to DONE; no iteration and busy is never raised.
- **RUN**, each cycle:
  - Shift {R,Q} left by one bit.
  - Compute trial T = {1'b0,R_shifted} − {1'b0,D} in WIDTH+1 bits.
  - If T[WIDTH] = 0: R = T[WIDTH-1:0] and Q[0] = 1. Otherwise R is kept (restore) and Q[0] = 0.
  - Counter increments. On the WIDTH-th iteration, copy Q and R to the Quotient and Remainder outputs and go to DONE.
- **DONE** lasts one cycle with done = 1.
  - start = 1 in DONE is accepted exactly as in IDLE: back-to-back operation with no dead cycle.
  - Otherwise go to IDLE.
- Quotient, Remainder and div_by_zero hold their last value until the next result overwrites them. They do not change during RUN.
- start while busy = 1 is ignored. Operand input changes after capture have no effect.
- All arithmetic is unsigned, with no overflow possible: Quotient ≤ Dividend, and Remainder < Divisor when Divisor != 0.

## Timing
- Edge 0 samples start.
- Normal divide:
  - busy is high from after edge 0 through edge WIDTH: WIDTH cycles, 4 by default.
  - The last iteration completes on edge WIDTH. done is high for the cycle after edge WIDTH, and the outputs are valid from the same edge.
  - Start-to-done latency is WIDTH+1 edges.
- Divide-by-zero: done and div_by_zero are high after edge 0 (latency 1 edge); busy stays 0.
- Back-to-back: if start is high in the DONE cycle, busy rises on the next edge. The second result's done arrives WIDTH+1 edges after the first.
- rst_n low at any time, including mid-RUN, immediately forces all reset values asynchronously. The operation in progress is abandoned and no done is produced. After deassertion the first start is accepted on the next rising edge.
- There are no combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- Dividend 13, Divisor 4: start for 1 cycle → busy high for 4 cycles, then done pulse; Quotient 3, Remainder 1, div_by_zero 0.
- Dividend 15, Divisor 1 → Quotient 15, Remainder 0. Then Dividend 3, Divisor 7 → Quotient 0, Remainder 3.
- Dividend 5, Divisor 0 → done one edge after start, busy never 1; Quotient 15, Remainder 5, div_by_zero 1.
  - Then 9 / 3 → div_by_zero clears, Quotient 3, Remainder 0.
- 13 / 4 started. Pulse start with 8 / 2 at RUN cycle 2, and change the operand inputs mid-run → result is still 3 remainder 1, with exactly one done.
- start held high continuously with 14 / 3 then 7 / 7 presented at each DONE cycle → results (4,2) then (1,0), done pulses exactly 5 edges apart.
- 15 / 2 started; rst_n pulled low after edge 2 → all outputs 0 immediately, no done. After release, 10 / 3 → Quotient 3, Remainder 1.
